// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: resolves source operands from ARF/ROB/CDB into a one-entry
// pipeline register that keeps snooping the CDB while stalled.
module operand_fetch_stage #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int NUM_SRC = 2,
  parameter int NUM_CDB = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SRC*XLEN-1:0]      arf_read_data,
  input  logic [NUM_SRC-1:0]           arf_busy,
  input  logic [NUM_SRC*TAG_W-1:0]     arf_tag,
  input  logic [NUM_SRC-1:0]           rob_valid,
  input  logic [NUM_SRC*XLEN-1:0]      rob_read_data,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_SRC*(XLEN+1)-1:0]  out_src,
  output logic [NUM_SRC-1:0]           out_src_rdy,
  output logic                         out_all_rdy
);
  logic valid_q, valid_d, accept;
  logic [NUM_SRC-1:0][XLEN:0] src_q, src_d, res, wake;
  // Scanning from the top down lets the lowest matching port overwrite last.
  function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] tag, input logic [XLEN:0] dflt);
    snoop = dflt;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) snoop = {1'b1, cdb_data[k*XLEN +: XLEN]};
  endfunction
  always_comb begin
    res  = '0;
    wake = src_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      res[i]  = !arf_busy[i] ? {1'b1, arf_read_data[i*XLEN +: XLEN]} :
                rob_valid[i] ? {1'b1, rob_read_data[i*XLEN +: XLEN]} :
                snoop(arf_tag[i*TAG_W +: TAG_W], {1'b0, XLEN'(arf_tag[i*TAG_W +: TAG_W])});
      wake[i] = src_q[i][XLEN] ? src_q[i] : snoop(src_q[i][TAG_W-1:0], src_q[i]);
    end
  end
  assign in_ready = !valid_q || out_ready;
  always_comb begin
    accept  = in_valid && in_ready && !flush;
    valid_d = !flush && (accept || (valid_q && !out_ready));
    src_d   = accept ? res : (valid_q && !out_ready && !flush) ? wake : src_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
    end
  always_comb begin
    out_src_rdy = '0;
    for (int i = 0; i < NUM_SRC; i++) out_src_rdy[i] = src_q[i][XLEN];
  end
  assign out_valid   = valid_q;
  assign out_src     = src_q;
  assign out_all_rdy = &out_src_rdy;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed scenarios plus random traffic against a
// rule-level model of the operand fetch register.
module tb_operand_fetch_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_all_rdy;
  logic [1:0] out_src_rdy;
  logic [65:0] out_src;
  logic        busy[2], robv[2], cv[2];
  logic [5:0]  tagv[2], ct[2];
  logic [31:0] arfd[2], robd[2], cd[2];
  logic        m_valid;
  logic [32:0] m_src[2];
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .arf_read_data({arfd[1], arfd[0]}), .arf_busy({busy[1], busy[0]}), .arf_tag({tagv[1], tagv[0]}),
    .rob_valid({robv[1], robv[0]}), .rob_read_data({robd[1], robd[0]}),
    .cdb_valid({cv[1], cv[0]}), .cdb_tag({ct[1], ct[0]}), .cdb_data({cd[1], cd[0]}),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_src_rdy(out_src_rdy), .out_all_rdy(out_all_rdy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] snoop(input logic [5:0] tag, input logic [32:0] dflt);
    for (int k = 0; k < 2; k++) if (cv[k] && ct[k] == tag) return {1'b1, cd[k]};
    return dflt;
  endfunction
  function automatic logic [32:0] resolve(input int i);
    if (!busy[i]) return {1'b1, arfd[i]};
    if (robv[i]) return {1'b1, robd[i]};
    return snoop(tagv[i], {1'b0, 26'b0, tagv[i]});
  endfunction
  task automatic clear_in();
    flush = 0; in_valid = 0; out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; robv[i] = 0; cv[i] = 0; tagv[i] = 0; ct[i] = 0; arfd[i] = 0; robd[i] = 0; cd[i] = 0;
    end
  endtask
  task automatic check_out();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("src%0d", i), out_src[i*33 +: 33], m_src[i]);
        chk($sformatf("rdy%0d", i), out_src_rdy[i], m_src[i][32]);
      end
      chk("all_rdy", out_all_rdy, m_src[0][32] && m_src[1][32]);
    end
  endtask
  task automatic step();
    logic acc, hold;
    logic [32:0] nxt[2];
    #1;
    chk("in_ready", in_ready, !m_valid || out_ready);
    acc  = in_valid && (!m_valid || out_ready) && !flush;
    hold = m_valid && !out_ready && !flush;
    for (int i = 0; i < 2; i++)
      nxt[i] = acc ? resolve(i) : (hold && !m_src[i][32]) ? snoop(m_src[i][5:0], m_src[i]) : m_src[i];
    @(posedge clk); #1;
    m_valid = !flush && (acc || (m_valid && !out_ready));
    m_src = nxt;
    check_out();
  endtask
  task automatic reset_model();
    m_valid = 0; m_src[0] = 0; m_src[1] = 0;
  endtask
  initial begin
    clear_in(); reset_model();
    #12 rst_n = 1;
    #1;
    chk("rst_valid", out_valid, 0); chk("rst_src", out_src, 0);
    chk("rst_rdy", out_src_rdy, 0); chk("rst_all", out_all_rdy, 0); chk("rst_in_ready", in_ready, 1);
    // resolve priority: ARF, then ROB over a matching CDB
    arfd[0] = 32'h11; busy[1] = 1; robv[1] = 1; robd[1] = 32'h22; tagv[1] = 3;
    cv[0] = 1; ct[0] = 3; cd[0] = 32'h33; in_valid = 1; out_ready = 1;
    step();
    chk("prio_src0", out_src[32:0], {1'b1, 32'h11}); chk("prio_src1", out_src[65:33], {1'b1, 32'h22});
    chk("prio_all", out_all_rdy, 1);
    // same-cycle CDB bypass, lowest port wins
    clear_in(); in_valid = 1; out_ready = 1; busy[1] = 1; tagv[1] = 5;
    cv[0] = 1; cv[1] = 1; ct[0] = 5; ct[1] = 5; cd[0] = 32'hAA; cd[1] = 32'hBB;
    step();
    chk("bypass_src1", out_src[65:33], {1'b1, 32'hAA});
    // stall wakeup
    clear_in(); in_valid = 1; out_ready = 1; busy[0] = 1; tagv[0] = 7; arfd[1] = 32'h55;
    step();
    chk("pend_src0", out_src[32:0], {1'b0, 32'h7}); chk("pend_all", out_all_rdy, 0);
    clear_in(); step();
    cv[1] = 1; ct[1] = 7; cd[1] = 32'hDEAD; step();
    chk("wake_src0", out_src[32:0], {1'b1, 32'hDEAD}); chk("wake_src1", out_src[65:33], {1'b1, 32'h55});
    cv[1] = 0; cd[1] = 32'hBEEF; step();
    chk("wake_keep", out_src[32:0], {1'b1, 32'hDEAD}); chk("wake_all", out_all_rdy, 1);
    // back-to-back throughput
    clear_in(); in_valid = 1; out_ready = 1;
    for (int n = 0; n < 4; n++) begin
      arfd[0] = 32'h100 + n; arfd[1] = 32'h200 + n;
      step();
      chk("b2b_ready", in_ready, 1); chk("b2b_valid", out_valid, 1);
      chk("b2b_src0", out_src[32:0], {1'b1, 32'h100 + n});
    end
    // flush beats accept while holding
    out_ready = 0; in_valid = 1; flush = 1; arfd[0] = 32'h999; step();
    chk("flush_valid", out_valid, 0);
    flush = 0; arfd[0] = 32'h777; step();
    chk("post_flush_valid", out_valid, 1); chk("post_flush_src0", out_src[32:0], {1'b1, 32'h777});
    // asynchronous reset in the middle of a hold
    in_valid = 0; step();
    #2 rst_n = 0;
    #1;
    chk("async_valid", out_valid, 0); chk("async_src", out_src, 0);
    reset_model();
    #1 rst_n = 1;
    #1 chk("async_in_ready", in_ready, 1);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid = $urandom_range(0, 1); out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      for (int i = 0; i < 2; i++) begin
        busy[i] = $urandom_range(0, 3) != 0; robv[i] = $urandom_range(0, 2) == 0;
        tagv[i] = 6'($urandom_range(0, 7)); arfd[i] = $urandom; robd[i] = $urandom;
        cv[i] = $urandom_range(0, 1); ct[i] = 6'($urandom_range(0, 7)); cd[i] = $urandom;
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
